// File: rtl/montgomery_pkg.sv
// Shared opcodes, error codes, status layout, command payload and FSM states
// for the Montgomery command controller.
package montgomery_pkg;

   localparam int unsigned STATUS_W   = 32;
   localparam int unsigned OP_W       = 4;
   localparam int unsigned SLOT_W     = 4;
   localparam int unsigned ERR_W      = 4;
   localparam int unsigned ST_OK_BIT  = 0;
   localparam int unsigned ST_ERR_LSB = 4;
   localparam int unsigned ST_OP_LSB  = 8;

   localparam logic [OP_W-1:0] OP_LOAD   = 4'd0;
   localparam logic [OP_W-1:0] OP_MUL    = 4'd1;
   localparam logic [OP_W-1:0] OP_STORE  = 4'd2;
   localparam logic [OP_W-1:0] OP_LOAD_M = 4'd3;
   localparam logic [OP_W-1:0] OP_CLEAR  = 4'd4;

   localparam logic [ERR_W-1:0] ERR_NONE   = 4'd0;
   localparam logic [ERR_W-1:0] ERR_OPCODE = 4'd1;
   localparam logic [ERR_W-1:0] ERR_SLOT   = 4'd2;
   localparam logic [ERR_W-1:0] ERR_NO_M   = 4'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_WAIT_IN, S_CORE_START,
      S_CORE_WAIT, S_WRITE_OUT, S_WAIT_OUT, S_RESPOND
   } state_e;

   typedef struct packed {
      logic [SLOT_W-1:0] src_b;
      logic [SLOT_W-1:0] src_a;
      logic [SLOT_W-1:0] dst;
      logic [OP_W-1:0]   opcode;
   } cmd_t;

   // Status word: ok flag, error code, echoed opcode; all other bits zero.
   function automatic logic [STATUS_W-1:0] make_status(input logic [OP_W-1:0]  op,
                                                       input logic [ERR_W-1:0] err);
      logic [STATUS_W-1:0] s;
      s                      = '0;
      s[ST_OK_BIT]           = (err == ERR_NONE);
      s[ST_ERR_LSB +: ERR_W] = err;
      s[ST_OP_LSB +: 8]      = 8'(op);
      return s;
   endfunction

endpackage

// File: rtl/mont_slot_regfile.sv
// Operand slot register file: one write port, bulk clear, three
// combinational read ports (srcA, srcB, dst).
module mont_slot_regfile
   import montgomery_pkg::*;
#(
   parameter int unsigned RSA_BITS  = 1024,
   parameter int unsigned NUM_SLOTS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                we_i,
   input  logic [SLOT_W-1:0]   waddr_i,
   input  logic [RSA_BITS-1:0] wdata_i,
   input  logic [SLOT_W-1:0]   raddr_a_i,
   input  logic [SLOT_W-1:0]   raddr_b_i,
   input  logic [SLOT_W-1:0]   raddr_d_i,
   output logic [RSA_BITS-1:0] rdata_a_c_o,
   output logic [RSA_BITS-1:0] rdata_b_c_o,
   output logic [RSA_BITS-1:0] rdata_d_c_o
);

   localparam int unsigned AW = $clog2(NUM_SLOTS);

   logic [RSA_BITS-1:0] slot_q [NUM_SLOTS];

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
      end else if (we_i && (32'(waddr_i) < NUM_SLOTS)) begin
         slot_q[waddr_i[AW-1:0]] <= wdata_i;
      end
   end

   // Out-of-range addresses read as zero; the controller never uses them.
   assign rdata_a_c_o = (32'(raddr_a_i) < NUM_SLOTS) ? slot_q[raddr_a_i[AW-1:0]] : '0;
   assign rdata_b_c_o = (32'(raddr_b_i) < NUM_SLOTS) ? slot_q[raddr_b_i[AW-1:0]] : '0;
   assign rdata_d_c_o = (32'(raddr_d_i) < NUM_SLOTS) ? slot_q[raddr_d_i[AW-1:0]] : '0;

endmodule

// File: rtl/montgomery_cmd_ctrl.sv
// Command-driven controller: decodes slot-addressed opcodes, moves operands
// to/from BRAM, sequences the external Montgomery multiplier, returns status.
module montgomery_cmd_ctrl
   import montgomery_pkg::*;
#(
   parameter int unsigned RSA_BITS  = 1024,
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned CMD_W     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CMD_W-1:0]    port1_din,
   input  logic                port1_valid,
   output logic                port1_read,
   output logic [CMD_W-1:0]    port2_dout,
   output logic                port2_valid,
   input  logic                port2_read,
   input  logic [RSA_BITS-1:0] bram_din,
   input  logic                bram_din_valid,
   output logic [RSA_BITS-1:0] bram_dout,
   output logic                bram_dout_valid,
   input  logic                bram_dout_read,
   output logic                core_start,
   output logic [RSA_BITS-1:0] core_a,
   output logic [RSA_BITS-1:0] core_b,
   output logic [RSA_BITS-1:0] core_m,
   input  logic                core_done,
   input  logic [RSA_BITS-1:0] core_result
);

   state_e              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic [STATUS_W-1:0] status_q, status_d;
   logic                m_loaded_q, m_loaded_d;
   logic [RSA_BITS-1:0] m_q, m_d;
   logic                p1_read_q, p1_read_d;
   logic                p2_valid_q, p2_valid_d;
   logic [CMD_W-1:0]    p2_dout_q, p2_dout_d;
   logic [RSA_BITS-1:0] bdout_q, bdout_d;
   logic                bdout_valid_q, bdout_valid_d;
   logic                cstart_q, cstart_d;
   logic [RSA_BITS-1:0] ca_q, ca_d, cb_q, cb_d, cm_q, cm_d;

   logic                rf_we_c, rf_clear_c;
   logic [RSA_BITS-1:0] rf_wdata_c, rd_a_c, rd_b_c, rd_dst_c;
   logic                dst_bad_c, a_bad_c, b_bad_c;
   logic [ERR_W-1:0]    err_c;
   logic                unused_din;

   assign unused_din = ^{port1_din[CMD_W-1:20], port1_din[7:4]};

   mont_slot_regfile #(
      .RSA_BITS (RSA_BITS),
      .NUM_SLOTS(NUM_SLOTS)
   ) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (rf_clear_c),
      .we_i       (rf_we_c),
      .waddr_i    (cmd_q.dst),
      .wdata_i    (rf_wdata_c),
      .raddr_a_i  (cmd_q.src_a),
      .raddr_b_i  (cmd_q.src_b),
      .raddr_d_i  (cmd_q.dst),
      .rdata_a_c_o(rd_a_c),
      .rdata_b_c_o(rd_b_c),
      .rdata_d_c_o(rd_dst_c)
   );

   assign dst_bad_c = 32'(cmd_q.dst)   >= NUM_SLOTS;
   assign a_bad_c   = 32'(cmd_q.src_a) >= NUM_SLOTS;
   assign b_bad_c   = 32'(cmd_q.src_b) >= NUM_SLOTS;

   // Error priority: bad opcode, then slot range on used fields, then missing M.
   always_comb begin
      err_c = ERR_NONE;
      case (cmd_q.opcode)
         OP_LOAD, OP_STORE:    err_c = dst_bad_c ? ERR_SLOT : ERR_NONE;
         OP_MUL: begin
            if (dst_bad_c || a_bad_c || b_bad_c) err_c = ERR_SLOT;
            else if (!m_loaded_q)                err_c = ERR_NO_M;
         end
         OP_LOAD_M, OP_CLEAR:  err_c = ERR_NONE;
         default:              err_c = ERR_OPCODE;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      status_d      = status_q;
      m_loaded_d    = m_loaded_q;
      m_d           = m_q;
      p1_read_d     = 1'b0;
      p2_valid_d    = p2_valid_q;
      p2_dout_d     = p2_dout_q;
      bdout_d       = bdout_q;
      bdout_valid_d = bdout_valid_q;
      cstart_d      = 1'b0;
      ca_d          = ca_q;
      cb_d          = cb_q;
      cm_d          = cm_q;
      rf_we_c       = 1'b0;
      rf_clear_c    = 1'b0;
      rf_wdata_c    = bram_din;

      case (state_q)
         S_IDLE: begin
            if (port1_valid) begin
               cmd_d     = '{src_b: port1_din[19:16], src_a: port1_din[15:12],
                             dst: port1_din[11:8], opcode: port1_din[3:0]};
               p1_read_d = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            status_d = make_status(cmd_q.opcode, err_c);
            if (err_c != ERR_NONE) begin
               state_d = S_RESPOND;
            end else begin
               case (cmd_q.opcode)
                  OP_LOAD, OP_LOAD_M: state_d = S_WAIT_IN;
                  OP_MUL:             state_d = S_CORE_START;
                  OP_STORE:           state_d = S_WRITE_OUT;
                  default: begin
                     rf_clear_c = 1'b1;
                     m_loaded_d = 1'b0;
                     state_d    = S_RESPOND;
                  end
               endcase
            end
         end
         S_WAIT_IN: begin
            if (bram_din_valid) begin
               if (cmd_q.opcode == OP_LOAD_M) begin
                  m_d        = bram_din;
                  m_loaded_d = 1'b1;
               end else begin
                  rf_we_c = 1'b1;
               end
               state_d = S_RESPOND;
            end
         end
         S_CORE_START: begin
            ca_d     = rd_a_c;
            cb_d     = rd_b_c;
            cm_d     = m_q;
            cstart_d = 1'b1;
            state_d  = S_CORE_WAIT;
         end
         S_CORE_WAIT: begin
            // Operands live in core_a/b registers, so dst may alias a source.
            if (core_done) begin
               rf_wdata_c = core_result;
               rf_we_c    = 1'b1;
               state_d    = S_RESPOND;
            end
         end
         S_WRITE_OUT: begin
            bdout_d       = rd_dst_c;
            bdout_valid_d = 1'b1;
            state_d       = S_WAIT_OUT;
         end
         S_WAIT_OUT: begin
            if (bdout_valid_q && bram_dout_read) begin
               bdout_valid_d = 1'b0;
               state_d       = S_RESPOND;
            end
         end
         S_RESPOND: begin
            p2_valid_d = 1'b1;
            p2_dout_d  = CMD_W'(status_q);
            if (p2_valid_q && port2_read) begin
               p2_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cmd_q         <= '0;
         status_q      <= '0;
         m_loaded_q    <= 1'b0;
         m_q           <= '0;
         p1_read_q     <= 1'b0;
         p2_valid_q    <= 1'b0;
         p2_dout_q     <= '0;
         bdout_q       <= '0;
         bdout_valid_q <= 1'b0;
         cstart_q      <= 1'b0;
         ca_q          <= '0;
         cb_q          <= '0;
         cm_q          <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         status_q      <= status_d;
         m_loaded_q    <= m_loaded_d;
         m_q           <= m_d;
         p1_read_q     <= p1_read_d;
         p2_valid_q    <= p2_valid_d;
         p2_dout_q     <= p2_dout_d;
         bdout_q       <= bdout_d;
         bdout_valid_q <= bdout_valid_d;
         cstart_q      <= cstart_d;
         ca_q          <= ca_d;
         cb_q          <= cb_d;
         cm_q          <= cm_d;
      end
   end

   assign port1_read      = p1_read_q;
   assign port2_valid     = p2_valid_q;
   assign port2_dout      = p2_dout_q;
   assign bram_dout       = bdout_q;
   assign bram_dout_valid = bdout_valid_q;
   assign core_start      = cstart_q;
   assign core_a          = ca_q;
   assign core_b          = cb_q;
   assign core_m          = cm_q;

endmodule

// File: tb/tb_montgomery_cmd_ctrl.sv
// Directed bench for montgomery_cmd_ctrl with a fixed-latency reference
// Montgomery core model.
module tb_montgomery_cmd_ctrl;
   import montgomery_pkg::*;

   localparam int unsigned W        = 1024;
   localparam int unsigned NS       = 4;
   localparam int unsigned CW       = 32;
   localparam int          CORE_LAT = 40;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] port1_din;
   logic          port1_valid, port1_read;
   logic [CW-1:0] port2_dout;
   logic          port2_valid, port2_read;
   logic [W-1:0]  bram_din, bram_dout;
   logic          bram_din_valid, bram_dout_valid, bram_dout_read;
   logic          core_start, core_done;
   logic [W-1:0]  core_a, core_b, core_m, core_result;

   logic          mdl_done = 1'b0, mdl_busy = 1'b0;
   logic [W-1:0]  mdl_result = '0;
   int            mdl_cnt = 0;
   logic          spur_done;
   logic [W-1:0]  spur_result;
   int            n_core_start = 0, n_bdv = 0;
   int            n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   montgomery_cmd_ctrl #(.RSA_BITS(W), .NUM_SLOTS(NS), .CMD_W(CW)) dut (
      .clk(clk), .reset(reset),
      .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
      .port2_dout(port2_dout), .port2_valid(port2_valid), .port2_read(port2_read),
      .bram_din(bram_din), .bram_din_valid(bram_din_valid),
      .bram_dout(bram_dout), .bram_dout_valid(bram_dout_valid), .bram_dout_read(bram_dout_read),
      .core_start(core_start), .core_a(core_a), .core_b(core_b), .core_m(core_m),
      .core_done(core_done), .core_result(core_result)
   );

   // Radix-2 reference: a*b*2^-W mod m (m odd, a,b < m).
   function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
      logic [W+1:0] s;
      s = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (a[i]) s = s + {2'b00, b};
         if (s[0]) s = s + {2'b00, m};
         s = s >> 1;
      end
      if (s >= {2'b00, m}) s = s - {2'b00, m};
      return s[W-1:0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         mdl_busy <= 1'b0;
         mdl_done <= 1'b0;
         mdl_cnt  <= 0;
      end else begin
         mdl_done <= 1'b0;
         if (core_start) begin
            mdl_busy   <= 1'b1;
            mdl_cnt    <= CORE_LAT - 1;
            mdl_result <= mont_ref(core_a, core_b, core_m);
         end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
               mdl_done <= 1'b1;
               mdl_busy <= 1'b0;
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (core_start)      n_core_start <= n_core_start + 1;
      if (bram_dout_valid) n_bdv        <= n_bdv + 1;
   end

   assign core_done   = mdl_done | spur_done;
   assign core_result = spur_done ? spur_result : mdl_result;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (low 128 bits)", tag, got[127:0], exp[127:0]);
      else
         n_pass++;
   endtask

   task automatic send_cmd(input logic [3:0] op, input logic [3:0] dst,
                           input logic [3:0] sa, input logic [3:0] sb);
      int n = 0;
      port1_din   = {12'd0, sb, sa, dst, 4'd0, op};
      port1_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!port1_read && n < 100);
      if (!port1_read) check("port1_read_timeout", W'(port1_read), W'(1'b1));
      port1_valid = 1'b0;
   endtask

   task automatic get_status(output logic [31:0] st);
      int n = 0;
      while (!port2_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!port2_valid) check("port2_valid_timeout", W'(port2_valid), W'(1'b1));
      st         = port2_dout;
      port2_read = 1'b1;
      @(negedge clk);
      port2_read = 1'b0;
   endtask

   task automatic load(input string tag, input logic [3:0] op, input logic [3:0] dst,
                       input logic [W-1:0] val, input logic [31:0] exp_st);
      logic [31:0] st;
      send_cmd(op, dst, 4'd0, 4'd0);
      @(negedge clk);
      bram_din       = val;
      bram_din_valid = 1'b1;
      @(negedge clk);
      bram_din_valid = 1'b0;
      if (exp_st[0]) begin
         check({tag, "_lat0"}, W'(port2_valid), W'(1'b0));
         @(negedge clk);
         check({tag, "_lat1"}, W'(port2_valid), W'(1'b1));
      end
      get_status(st);
      check({tag, "_status"}, W'(st), W'(exp_st));
   endtask

   task automatic mul(input string tag, input logic [3:0] dst, input logic [3:0] sa,
                      input logic [3:0] sb, input logic [31:0] exp_st);
      logic [31:0] st;
      send_cmd(OP_MUL, dst, sa, sb);
      get_status(st);
      check({tag, "_status"}, W'(st), W'(exp_st));
   endtask

   task automatic store(input string tag, input logic [3:0] dst, input logic [W-1:0] exp_d);
      logic [31:0] st;
      int n = 0;
      send_cmd(OP_STORE, dst, 4'd0, 4'd0);
      while (!bram_dout_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_data"}, bram_dout, exp_d);
      bram_dout_read = 1'b1;
      @(negedge clk);
      bram_dout_read = 1'b0;
      get_status(st);
      check({tag, "_status"}, W'(st), W'(32'h0000_0201));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] st;
      logic [W-1:0] big_m, d;
      int bad, n, cs0, bv0;

      reset = 1'b1; port1_din = '0; port1_valid = 1'b0; port2_read = 1'b0;
      bram_din = '0; bram_din_valid = 1'b0; bram_dout_read = 1'b0;
      spur_done = 1'b0; spur_result = '0;
      big_m = {8{128'hF1E2_D3C4_B5A6_9788_796A_5B4C_3D2E_1F0F}};
      repeat (3) @(negedge clk);
      check("rst_port1_read",  W'(port1_read), W'(1'b0));
      check("rst_port2_valid", W'(port2_valid), W'(1'b0));
      check("rst_port2_dout",  W'(port2_dout), W'(0));
      check("rst_bdout_valid", W'(bram_dout_valid), W'(1'b0));
      check("rst_core_start",  W'(core_start), W'(1'b0));
      check("rst_core_a",      core_a, '0);
      reset = 1'b0;
      @(negedge clk);

      // Errors straight after reset
      mul("mul_no_m", 4'd2, 4'd0, 4'd1, 32'h0000_0130);
      load("load_bad_slot", OP_LOAD, 4'd5, W'(32'hDEAD), 32'h0000_0020);
      store("s0_untouched", 4'd0, '0);
      store("s1_untouched", 4'd1, '0);

      // Small operands: 1*2*2^-1024 mod 3 = 2
      load("t1_ld0", OP_LOAD, 4'd0, W'(1), 32'h0000_0001);
      load("t1_ld1", OP_LOAD, 4'd1, W'(2), 32'h0000_0001);
      load("t1_ldm", OP_LOAD_M, 4'd0, W'(3), 32'h0000_0301);
      mul("t1_mul", 4'd2, 4'd0, 4'd1, 32'h0000_0101);
      store("t1_st2", 4'd2, W'(2));

      // Wide modulus, in-place result
      load("t2_ld0", OP_LOAD, 4'd0, W'(32'h1BA), 32'h0000_0001);
      load("t2_ld1", OP_LOAD, 4'd1, W'(32'h91B), 32'h0000_0001);
      load("t2_ldm", OP_LOAD_M, 4'd0, big_m, 32'h0000_0301);
      mul("t2_mul", 4'd0, 4'd0, 4'd1, 32'h0000_0101);
      store("t2_st0", 4'd0, mont_ref(W'(32'h1BA), W'(32'h91B), big_m));
      store("t2_st1", 4'd1, W'(32'h91B));

      // Bad opcode: no BRAM or core activity
      cs0 = n_core_start; bv0 = n_bdv;
      send_cmd(4'hF, 4'd0, 4'd0, 4'd0);
      get_status(st);
      check("badop_status", W'(st), W'(32'h0000_0F10));
      check("badop_no_core", W'(n_core_start), W'(cs0));
      check("badop_no_bdv",  W'(n_bdv), W'(bv0));

      // CLEAR: latency, slots zeroed, M forgotten
      load("cl_ld0", OP_LOAD, 4'd0, W'(7), 32'h0000_0001);
      send_cmd(OP_CLEAR, 4'd0, 4'd0, 4'd0);
      check("clear_lat0", W'(port2_valid), W'(1'b0));
      @(negedge clk);
      check("clear_lat1", W'(port2_valid), W'(1'b0));
      @(negedge clk);
      check("clear_lat2", W'(port2_valid), W'(1'b1));
      get_status(st);
      check("clear_status", W'(st), W'(32'h0000_0401));
      store("clear_s0", 4'd0, '0);
      mul("clear_mul", 4'd2, 4'd0, 4'd1, 32'h0000_0130);

      // Status held while host stalls; pending command waits
      send_cmd(OP_CLEAR, 4'd0, 4'd0, 4'd0);
      n = 0;
      while (!port2_valid && n < 20) begin @(negedge clk); n++; end
      port1_din = {28'd0, OP_CLEAR}; port1_valid = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!port2_valid || port1_read) bad++;
      end
      check("hold_status", W'(bad), W'(0));
      port2_read = 1'b1; @(negedge clk); port2_read = 1'b0;
      n = 0;
      while (!port1_read && n < 10) begin @(negedge clk); n++; end
      check("pending_accept", W'(port1_read), W'(1'b1));
      port1_valid = 1'b0;
      get_status(st);
      check("pending_status", W'(st), W'(32'h0000_0401));

      // bram_dout held while BRAM stalls
      load("hb_ld3", OP_LOAD, 4'd3, W'(32'hABCD_1234), 32'h0000_0001);
      send_cmd(OP_STORE, 4'd3, 4'd0, 4'd0);
      n = 0;
      while (!bram_dout_valid && n < 20) begin @(negedge clk); n++; end
      d = bram_dout;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bram_dout_valid || bram_dout !== d) bad++;
      end
      check("hold_bdout", W'(bad), W'(0));
      check("hold_bdout_val", d, W'(32'hABCD_1234));
      bram_dout_read = 1'b1; @(negedge clk); bram_dout_read = 1'b0;
      get_status(st);
      check("hold_st_status", W'(st), W'(32'h0000_0201));

      // Reset during CORE_WAIT
      load("r_ld0", OP_LOAD, 4'd0, W'(5), 32'h0000_0001);
      load("r_ld1", OP_LOAD, 4'd1, W'(6), 32'h0000_0001);
      load("r_ldm", OP_LOAD_M, 4'd0, W'(7), 32'h0000_0301);
      send_cmd(OP_MUL, 4'd2, 4'd0, 4'd1);
      n = 0;
      while (!core_start && n < 10) begin @(negedge clk); n++; end
      check("r_core_start", W'(core_start), W'(1'b1));
      repeat (10) @(negedge clk);
      check("r_core_a", core_a, W'(5));
      check("r_core_b", core_b, W'(6));
      check("r_core_m", core_m, W'(7));
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      check("mr_port1_read",  W'(port1_read), W'(1'b0));
      check("mr_port2_valid", W'(port2_valid), W'(1'b0));
      check("mr_port2_dout",  W'(port2_dout), W'(0));
      check("mr_bdout_valid", W'(bram_dout_valid), W'(1'b0));
      check("mr_bdout",       bram_dout, '0);
      check("mr_core_start",  W'(core_start), W'(1'b0));
      check("mr_core_abm",    core_a | core_b | core_m, '0);
      spur_result = W'(32'h99);
      spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (port2_valid || port1_read || core_start) bad++;
      end
      check("mr_quiet", W'(bad), W'(0));
      send_cmd(OP_LOAD, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
      bram_din = W'(32'h55); bram_din_valid = 1'b1;
      @(negedge clk);
      bram_din_valid = 1'b0;
      get_status(st);
      check("mr_load_status", W'(st), W'(32'h0000_0001));
      store("mr_st0", 4'd0, W'(32'h55));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
